// File: rtl/dcp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | dcp_pkg : constants and helpers shared by the dark-channel prior stages
// | Revision: 1.0
// +----------------------------------------------------------------------------
package dcp_pkg;

  localparam int                PIX_W     = 8;
  localparam logic [PIX_W-1:0]  PIX_MAX   = 8'hFF;
  localparam int                DEF_K     = 3;
  localparam int                DEF_IMG_W = 640;
  localparam int                DEF_IMG_H = 480;

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/col_min_k_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | line_buffer : one image line of pixel minima, synchronous read, read-first
// | Revision: 1.0
// +----------------------------------------------------------------------------
module line_buffer
  import dcp_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [PIX_W-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [PIX_W-1:0] wr_data_i
);

  logic [PIX_W-1:0] mem_q [IMG_W];
  logic [PIX_W-1:0] rd_q;

  // Contents are deliberately left unreset; the consumer masks stale rows.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_q;

endmodule
`default_nettype wire

// File: rtl/col_min_k.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | col_min_k : vertical K-row minimum of per-pixel channel minima
// | Revision: 1.0
// +----------------------------------------------------------------------------
module col_min_k
  import dcp_pkg::*;
#(
  parameter int K     = DEF_K,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic             sof,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic             out_en,
  output logic [PIX_W-1:0] column_min,
  output logic             frame_done
);

  localparam int            CW       = $clog2(IMG_W);
  localparam int            RW       = $clog2(IMG_H);
  localparam int            NB       = K - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d, pix_col;
  logic [RW-1:0]    row_q, row_d, pix_row;
  logic [PIX_W-1:0] pmin;

  logic             s1_valid_q, s2_valid_q;
  logic [PIX_W-1:0] s1_pmin_q, s2_pmin_q;
  logic [CW-1:0]    s1_col_q, s2_col_q;
  logic [RW-1:0]    s1_row_q, s2_row_q;

  logic [PIX_W-1:0] lb_rd     [NB];
  logic [PIX_W-1:0] lb_masked [NB];
  logic [PIX_W-1:0] min_d;

  logic             out_en_q, frame_done_q;
  logic [PIX_W-1:0] column_min_q;

  assign pmin = min2(min2(r, g), b);

  always_comb begin
    pix_col = sof ? '0 : col_q;
    pix_row = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_en) begin
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
      end else begin
        col_d = pix_col + CW'(1);
        row_d = pix_row;
      end
    end
  end

  // Stage 1 captures the pixel, the RAM read happens on the next edge and the
  // cascade write-back one edge later, using the data that read returned.
  generate
    for (genvar j = 0; j < NB; j++) begin : g_lb
      logic [PIX_W-1:0] wr_data;
      if (j == 0) begin : g_head
        assign wr_data = s2_pmin_q;
      end else begin : g_tail
        assign wr_data = lb_rd[j-1];
      end

      line_buffer #(.IMG_W(IMG_W)) u_lb (
        .clk       (clk),
        .rd_en_i   (s1_valid_q),
        .rd_addr_i (s1_col_q),
        .rd_data_o (lb_rd[j]),
        .wr_en_i   (s2_valid_q & rst_n),
        .wr_addr_i (s2_col_q),
        .wr_data_i (wr_data)
      );

      assign lb_masked[j] = (int'(s2_row_q) <= j) ? PIX_MAX : lb_rd[j];
    end
  endgenerate

  always_comb begin
    min_d = s2_pmin_q;
    for (int j = 0; j < NB; j++) begin
      min_d = min2(min_d, lb_masked[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_pmin_q    <= '0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_pmin_q    <= '0;
      s2_col_q     <= '0;
      s2_row_q     <= '0;
      out_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      column_min_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      s1_valid_q <= in_en;
      if (in_en) begin
        s1_pmin_q <= pmin;
        s1_col_q  <= pix_col;
        s1_row_q  <= pix_row;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_pmin_q <= s1_pmin_q;
        s2_col_q  <= s1_col_q;
        s2_row_q  <= s1_row_q;
      end
      out_en_q     <= s2_valid_q;
      frame_done_q <= s2_valid_q && (s2_col_q == COL_LAST) && (s2_row_q == ROW_LAST);
      if (s2_valid_q) column_min_q <= min_d;
    end
  end

  assign out_en     = out_en_q;
  assign column_min = column_min_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
